// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types and constants for the data-memory responder:
//                FSM state enum, latched operation encoding, word size and
//                the byte-address alignment mask, plus the error classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_BAD   = 2'd2
    } op_t;

    localparam int          WORD_BYTES      = 4;
    localparam logic [31:0] ADDR_ALIGN_MASK = 32'(WORD_BYTES - 1);

    // A latched request is rejected when it was a double request, is not
    // word aligned, or addresses a word beyond the array.
    function automatic logic addr_error(input logic [31:0] addr,
                                        input op_t         op,
                                        input int          idx_w);
        logic [29:0] word;
        word = addr[31:2];
        return (op == OP_BAD)
            || ((addr & ADDR_ALIGN_MASK) != 32'd0)
            || ((word >> idx_w) != 30'd0);
    endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/data_memory_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_responder_if
//  Description : CPU data-memory bus: level-sensitive load/store request and
//                registered ready/busy/error/ReadData response.
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_memory_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] writeData;
    logic [31:0] ReadData;
    logic        ready;
    logic        busy;
    logic        error;

    modport master (
        output MemRead, MemWrite, Address, writeData,
        input  ReadData, ready, busy, error
    );

    modport slave (
        input  MemRead, MemWrite, Address, writeData,
        output ReadData, ready, busy, error
    );
endinterface : data_memory_responder_if
`default_nettype wire

// File: rtl/data_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_array
//  Description : DEPTH_WORDS x 32 storage, synchronous write and
//                combinational read by word index.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  wire logic             clock,
    input  wire logic             we_i,
    input  wire logic [IDX_W-1:0] widx_i,
    input  wire logic [31:0]      wdata_i,
    input  wire logic [IDX_W-1:0] ridx_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Store the word on the clock edge when the responder commits a write.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[ridx_i];

endmodule : data_mem_array
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_responder
//  Description : Wait-state data-memory responder. Accepts a load/store in
//                IDLE, waits WAIT_STATES cycles, then completes it with a
//                registered one-cycle ready pulse (with error/ReadData).
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  wire logic              clock,
    input  wire logic              reset,
    data_memory_responder_if.slave bus
);

    localparam int         IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] c_wait_cnt = 4'(WAIT_STATES);

    state_t      state_q;
    logic [3:0]  cnt_q;
    op_t         op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        ready_q;
    logic        busy_q;
    logic        error_q;
    logic [31:0] rdata_q;

    logic             w_req;
    op_t              w_op_in;
    logic             w_err;
    logic [IDX_W-1:0] w_idx;
    logic             w_we;
    logic [31:0]      w_rdata;

    assign w_req = bus.MemRead | bus.MemWrite;
    assign w_err = addr_error(addr_q, op_q, IDX_W);
    assign w_idx = addr_q[2 +: IDX_W];
    // Writes commit on the edge that leaves RESP, and only for clean stores.
    assign w_we  = (state_q == RESP) && (op_q == OP_WRITE) && !w_err;

    // Classify the incoming request; a simultaneous load+store is illegal.
    always_comb begin
        w_op_in = OP_READ;
        if (bus.MemRead && bus.MemWrite) begin
            w_op_in = OP_BAD;
        end else if (bus.MemWrite) begin
            w_op_in = OP_WRITE;
        end
    end

    data_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clock   (clock),
        .we_i    (w_we),
        .widx_i  (w_idx),
        .wdata_i (wdata_q),
        .ridx_i  (w_idx),
        .rdata_o (w_rdata)
    );

    // Transaction FSM; every bus output is a register so no input reaches an
    // output combinationally. The response lands in the cycle after RESP.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= OP_READ;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= 32'd0;
            case (state_q)
                IDLE: begin
                    busy_q <= w_req;
                    if (w_req) begin
                        op_q    <= w_op_in;
                        addr_q  <= bus.Address;
                        wdata_q <= bus.writeData;
                        cnt_q   <= c_wait_cnt;
                        state_q <= (c_wait_cnt == 4'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    busy_q <= 1'b1;
                    if (cnt_q <= 4'd1) begin
                        cnt_q   <= 4'd0;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    // busy stays up through the ready cycle that follows
                    busy_q  <= 1'b1;
                    ready_q <= 1'b1;
                    error_q <= w_err;
                    rdata_q <= ((op_q == OP_READ) && !w_err) ? w_rdata : 32'd0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ReadData = rdata_q;
    assign bus.ready    = ready_q;
    assign bus.busy     = busy_q;
    assign bus.error    = error_q;

endmodule : data_memory_responder
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory_responder
//  Description : Self-checking bench: directed scenarios plus random
//                transactions against a word-array reference model, on a
//                WAIT_STATES=2 instance and a WAIT_STATES=0 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_responder;

    localparam int WA = 2;
    localparam int WB = 0;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    bit [31:0] model_mem [256];

    data_memory_responder_if bus_a ();
    data_memory_responder_if bus_b ();

    data_memory_responder #(.DEPTH_WORDS(256), .WAIT_STATES(WA)) u_dut_a (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus_a)
    );

    data_memory_responder #(.DEPTH_WORDS(256), .WAIT_STATES(WB)) u_dut_b (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance A. The request is dropped right after
    // acceptance and Address is moved to alt_addr so a stale latch shows up.
    task automatic txn_a(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] alt_addr);
        bit        err;
        bit [31:0] exp_rd;
        err    = (rd && wr) || (addr[1:0] != 2'b00) || (addr >= 32'd1024);
        exp_rd = (rd && !wr && !err) ? model_mem[addr[9:2]] : 32'd0;
        bus_a.MemRead   = rd;
        bus_a.MemWrite  = wr;
        bus_a.Address   = addr;
        bus_a.writeData = data;
        @(posedge clk); #1;
        bus_a.MemRead   = 1'b0;
        bus_a.MemWrite  = 1'b0;
        bus_a.Address   = alt_addr;
        bus_a.writeData = $urandom;
        check("busy_after_accept", {31'd0, bus_a.busy}, 32'd1);
        for (int k = 1; k <= WA; k++) begin
            @(posedge clk); #1;
            check("ready_early", {31'd0, bus_a.ready}, 32'd0);
            check("rdata_idle", bus_a.ReadData, 32'd0);
        end
        @(posedge clk); #1;
        check("ready", {31'd0, bus_a.ready}, 32'd1);
        check("error", {31'd0, bus_a.error}, {31'd0, err});
        check("rdata", bus_a.ReadData, exp_rd);
        check("busy_in_ready", {31'd0, bus_a.busy}, 32'd1);
        if (wr && !rd && !err) model_mem[addr[9:2]] = data;
    endtask

    initial begin
        logic [31:0] a;
        int          op;
        int          kind;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
        bus_a.MemRead = 1'b0; bus_a.MemWrite = 1'b0; bus_a.Address = 32'd0; bus_a.writeData = 32'd0;
        bus_b.MemRead = 1'b0; bus_b.MemWrite = 1'b0; bus_b.Address = 32'd0; bus_b.writeData = 32'd0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, bus_a.ready}, 32'd0);
        check("rst_busy",  {31'd0, bus_a.busy},  32'd0);
        check("rst_error", {31'd0, bus_a.error}, 32'd0);
        check("rst_rdata", bus_a.ReadData, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", {31'd0, bus_a.busy}, 32'd0);

        // Known contents for the words the bench touches
        for (int i = 0; i < 16; i++) txn_a(1'b0, 1'b1, 32'(i * 4), 32'd0, 32'(i * 4));

        // Basic write/read
        txn_a(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h10);
        txn_a(1'b1, 1'b0, 32'h10, 32'd0, 32'h10);

        // Misaligned and out-of-range
        txn_a(1'b0, 1'b1, 32'h0, 32'h0BAD_F00D, 32'h0);
        txn_a(1'b1, 1'b0, 32'h12, 32'd0, 32'h12);
        txn_a(1'b0, 1'b1, 32'h400, 32'h1111_2222, 32'h400);
        txn_a(1'b1, 1'b0, 32'h0, 32'd0, 32'h0);

        // Illegal double request
        txn_a(1'b1, 1'b1, 32'h20, 32'hCAFE_0020, 32'h20);
        txn_a(1'b1, 1'b0, 32'h20, 32'd0, 32'h20);

        // Address changed while waiting: response must use the latched 0x10
        txn_a(1'b0, 1'b1, 32'h14, 32'h5555_0014, 32'h14);
        txn_a(1'b1, 1'b0, 32'h10, 32'd0, 32'h14);

        // Reset while in WAIT aborts the store
        bus_a.MemWrite  = 1'b1;
        bus_a.Address   = 32'h08;
        bus_a.writeData = 32'h12345678;
        @(posedge clk); #1;
        bus_a.MemWrite = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_busy", {31'd0, bus_a.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy",  {31'd0, bus_a.busy},  32'd0);
        check("async_rst_ready", {31'd0, bus_a.ready}, 32'd0);
        check("async_rst_rdata", bus_a.ReadData, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", {31'd0, bus_a.busy}, 32'd0);
        txn_a(1'b1, 1'b0, 32'h08, 32'd0, 32'h08);

        // Random traffic against the model
        for (int n = 0; n < 40; n++) begin
            op   = $urandom_range(0, 9);
            kind = $urandom_range(0, 9);
            if (kind == 0)      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else if (kind == 1) a = ($urandom | 32'h400) & ~32'h3;
            else                a = 32'($urandom_range(0, 15) * 4);
            if (op == 0)      txn_a(1'b1, 1'b1, a, $urandom, a);
            else if (op < 5)  txn_a(1'b1, 1'b0, a, 32'd0, a);
            else              txn_a(1'b0, 1'b1, a, $urandom, a);
        end

        // Zero wait states: seed 0x04, then hold a load for back-to-back reads
        bus_b.MemWrite  = 1'b1;
        bus_b.Address   = 32'h04;
        bus_b.writeData = 32'hA5A5_0004;
        @(posedge clk); #1;
        bus_b.MemWrite = 1'b0;
        @(posedge clk); #1;
        check("b_wr_ready", {31'd0, bus_b.ready}, 32'd1);
        check("b_wr_error", {31'd0, bus_b.error}, 32'd0);
        bus_b.MemRead = 1'b1;
        @(posedge clk); #1;
        check("b_acc_busy", {31'd0, bus_b.busy}, 32'd1);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            check("b2b_ready", {31'd0, bus_b.ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            check("b2b_rdata", bus_b.ReadData, (k % 2 == 1) ? 32'hA5A5_0004 : 32'd0);
            check("b2b_busy",  {31'd0, bus_b.busy}, 32'd1);
        end
        bus_b.MemRead = 1'b0;
        @(posedge clk); #1;
        check("b_end_busy",  {31'd0, bus_b.busy},  32'd0);
        check("b_end_ready", {31'd0, bus_b.ready}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_data_memory_responder
`default_nettype wire
